// File: rtl/spi_master_scheduler.sv
// -----------------------------------------------------------------------------
// spi_master_scheduler
// Round-robin arbiter that time-shares one SPI Master among three requesters,
// one per slave-select code. The scheduler picks a winner and latches its
// transmit byte. It pulses the Master's start and times the transfer with a
// down-counter. It then captures the received byte and returns it with a
// one-cycle done pulse.
//
// Ports
//   clk              system clock, rising edge
//   reset            asynchronous active-low reset
//   req[2:0]         per-requester transfer request, held until done
//   req_data[23:0]   transmit byte of requester i at [8i+7:8i]
//   gnt[2:0]         one-hot owner of the Master
//   done[2:0]        one-cycle completion pulse for the owner
//   rx_data[7:0]     received byte, valid with done, held until next done
//   busy             high whenever the scheduler is not idle
//   m_start          Master start, high for the single LOAD cycle
//   m_slaveselect    Master slave select (00/01/10 = requester 0/1/2)
//   m_data_to_send   Master transmit byte (latched at grant)
//   m_data_received  Master received byte
// -----------------------------------------------------------------------------
module spi_master_scheduler #(
   parameter int XFER_CYCLES = 9,
   parameter int GAP_CYCLES  = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [2:0]  req,
   input  logic [23:0] req_data,
   output logic [2:0]  gnt,
   output logic [2:0]  done,
   output logic [7:0]  rx_data,
   output logic        busy,
   output logic        m_start,
   output logic [1:0]  m_slaveselect,
   output logic [7:0]  m_data_to_send,
   input  logic [7:0]  m_data_received
);

   localparam int CNT_MAX = (XFER_CYCLES > GAP_CYCLES) ? XFER_CYCLES : GAP_CYCLES;
   localparam int CNT_W   = (CNT_MAX >= 2) ? $clog2(CNT_MAX) : 1;
   localparam logic [CNT_W-1:0] XFER_LOAD = CNT_W'(XFER_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_XFER,
      S_DONE,
      S_GAP
   } state_t;

   state_t           r_state;
   logic [2:0]       r_gnt;
   logic [2:0]       r_done;
   logic [7:0]       r_rx_data;
   logic             r_busy;
   logic             r_m_start;
   logic [1:0]       r_m_ss;
   logic [7:0]       r_m_data;
   logic [CNT_W-1:0] r_counter;
   logic [1:0]       r_rr_ptr;

   logic [1:0]       w_winner;
   logic [7:0]       w_win_byte;

   // Round-robin search starts just after the last served requester.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can
      // leave it unassigned and infer a latch.
      w_winner   = 2'd0;
      w_win_byte = 8'h00;
      case (r_rr_ptr)
         2'd0:    w_winner = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
         2'd1:    w_winner = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
         default: w_winner = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
      endcase
      case (w_winner)
         2'd0:    w_win_byte = req_data[7:0];
         2'd1:    w_win_byte = req_data[15:8];
         default: w_win_byte = req_data[23:16];
      endcase
   end

   // NOTE: state is updated with non-blocking assignments and cleared by the
   // asynchronous reset branch, so every register leaves reset together.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= S_IDLE;
         r_gnt     <= 3'b000;
         r_done    <= 3'b000;
         r_rx_data <= 8'h00;
         r_busy    <= 1'b0;
         r_m_start <= 1'b0;
         r_m_ss    <= 2'b00;
         r_m_data  <= 8'h00;
         r_counter <= '0;
         r_rr_ptr  <= 2'd2;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (req != 3'b000) begin
                  r_state   <= S_LOAD;
                  r_gnt     <= 3'b001 << w_winner;
                  r_m_ss    <= w_winner;
                  r_m_data  <= w_win_byte;
                  r_m_start <= 1'b1;
                  r_busy    <= 1'b1;
               end
            end
            S_LOAD: begin
               r_state   <= S_XFER;
               r_m_start <= 1'b0;
               r_counter <= XFER_LOAD;
            end
            S_XFER: begin
               if (r_counter == '0) begin
                  r_state   <= S_DONE;
                  r_rx_data <= m_data_received;
                  r_done    <= r_gnt;
               end else begin
                  r_counter <= r_counter - CNT_W'(1);
               end
            end
            S_DONE: begin
               // The slave-select code doubles as the owner index.
               r_gnt    <= 3'b000;
               r_done   <= 3'b000;
               r_rr_ptr <= r_m_ss;
               if (GAP_CYCLES == 0) begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end else begin
                  r_state   <= S_GAP;
                  r_counter <= GAP_LOAD;
               end
            end
            S_GAP: begin
               if (r_counter == '0) begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end else begin
                  r_counter <= r_counter - CNT_W'(1);
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_gnt   <= 3'b000;
               r_done  <= 3'b000;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign gnt            = r_gnt;
   assign done           = r_done;
   assign rx_data        = r_rx_data;
   assign busy           = r_busy;
   assign m_start        = r_m_start;
   assign m_slaveselect  = r_m_ss;
   assign m_data_to_send = r_m_data;

endmodule
